// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the EX stage and the
// iterative multiply/divide unit.
//   start       : request, sampled by the unit only while idle
//   op          : RV32M operation select (MUL..REMU)
//   a, b        : rs1 / rs2 operands
//   flush       : abandon the in-flight operation
//   busy        : operation in progress
//   done        : one-cycle result-valid pulse
//   result      : registered result, held until the next done
//   div_by_zero : qualified by done, divide/remainder with b == 0
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, fixed latency WIDTH+2
// cycles from the start edge to done for every op and operand value.
//   clk1  : processor clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_unit_if slave (start/op/a/b/flush in,
//           busy/done/result/div_by_zero out)
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// PREP  | record signs, load magnitudes and iteration counter
// ITER  | one shift-add (mul) or restoring (div) step per cycle, WIDTH steps
// FIX   | apply signs, select result, pulse done
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk1,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t             state;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign_a;
    logic               sign_b;
    logic [2*WIDTH-1:0] work;
    logic [CW-1:0]      cnt;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   new_rem;
    logic [2*WIDTH-1:0] work_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_res;
    logic               fix_dbz;

    // a is signed for MUL/MULH/MULHSU/DIV/REM, b for MUL/MULH/DIV/REM
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (op_r[2]) begin
            a_neg = ~op_r[0] & a_r[WIDTH-1];
            b_neg = ~op_r[0] & b_r[WIDTH-1];
        end else begin
            a_neg = (op_r[1:0] != 2'b11) & a_r[WIDTH-1];
            b_neg = ~op_r[1] & b_r[WIDTH-1];
        end
        abs_a = a_neg ? -a_r : a_r;
        abs_b = b_neg ? -b_r : b_r;
    end

    // work holds {acc, multiplier} for multiply and {remainder, quotient}
    // for divide; both shift one bit per ITER cycle.
    always_comb begin
        mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mag_a} : '0);
        rem_sh   = work[2*WIDTH-1:WIDTH-1];
        div_diff = rem_sh - {1'b0, mag_b};
        new_rem  = div_diff[WIDTH] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
        if (op_r[2])
            work_step = {new_rem, work[WIDTH-2:0], ~div_diff[WIDTH]};
        else
            work_step = {mul_sum, work[WIDTH-1:1]};
    end

    always_comb begin
        prod    = (sign_a ^ sign_b) ? -work : work;
        quo     = work[WIDTH-1:0];
        rem     = work[2*WIDTH-1:WIDTH];
        fix_res = prod[WIDTH-1:0];
        fix_dbz = 1'b0;
        case (op_r)
            3'b000: fix_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (b_r == '0) begin
                    fix_res = '1;
                    fix_dbz = 1'b1;
                end else begin
                    fix_res = (sign_a ^ sign_b) ? -quo : quo;
                end
            end
            default: begin
                if (b_r == '0) begin
                    // remainder returns the raw dividend, not its magnitude
                    fix_res = a_r;
                    fix_dbz = 1'b1;
                end else begin
                    fix_res = sign_a ? -rem : rem;
                end
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            op_r            <= '0;
            a_r             <= '0;
            b_r             <= '0;
            mag_a           <= '0;
            mag_b           <= '0;
            sign_a          <= 1'b0;
            sign_b          <= 1'b0;
            work            <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.flush) begin
                // also drops a start presented in IDLE
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            op_r     <= bus.op;
                            a_r      <= bus.a;
                            b_r      <= bus.b;
                            bus.busy <= 1'b1;
                            state    <= PREP;
                        end
                    end
                    PREP: begin
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        work   <= {{WIDTH{1'b0}}, (op_r[2] ? abs_a : abs_b)};
                        cnt    <= CW'(WIDTH - 1);
                        state  <= ITER;
                    end
                    ITER: begin
                        work <= work_step;
                        if (cnt == '0)
                            state <= FIX;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    FIX: begin
                        bus.result      <= fix_res;
                        bus.div_by_zero <= fix_dbz;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomised checks of muldiv_unit at
// WIDTH=32 and WIDTH=8 against hand-computed values and a reference model.
module tb_muldiv_unit;
    logic clk1;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_unit_if #(.WIDTH(32)) i32 ();
    muldiv_unit_if #(.WIDTH(8))  i8 ();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk1(clk1), .rst_n(rst_n), .bus(i32));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk1(clk1), .rst_n(rst_n), .bus(i8));

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                           DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic st, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y, input logic fl);
        if (sel == 32) begin
            i32.start = st; i32.op = o; i32.a = x; i32.b = y; i32.flush = fl;
        end else begin
            i8.start = st; i8.op = o; i8.a = x[7:0]; i8.b = y[7:0]; i8.flush = fl;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 32) ? i32.busy : i8.busy;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel == 32) ? i32.done : i8.done;
    endfunction
    function automatic logic get_dbz(input int sel);
        return (sel == 32) ? i32.div_by_zero : i8.div_by_zero;
    endfunction
    function automatic logic [31:0] get_res(input int sel);
        return (sel == 32) ? i32.result : {24'b0, i8.result};
    endfunction

    // arithmetic reference: sign/zero extend to 64 bits and use native ops
    function automatic void model(input int w, input logic [2:0] o,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic z);
        logic [63:0] mask, xu, yu, xs, ys, p;
        mask = (64'd1 << w) - 64'd1;
        xu = {32'b0, x} & mask;
        yu = {32'b0, y} & mask;
        xs = xu[w-1] ? (xu | ~mask) : xu;
        ys = yu[w-1] ? (yu | ~mask) : yu;
        z = 1'b0;
        case (o)
            MUL:    p = xs * ys;
            MULH:   p = (xs * ys) >> w;
            MULHSU: p = (xs * yu) >> w;
            MULHU:  p = (xu * yu) >> w;
            DIV:    if (yu == 0) begin p = mask; z = 1'b1; end
                    else p = $unsigned($signed(xs) / $signed(ys));
            DIVU:   if (yu == 0) begin p = mask; z = 1'b1; end
                    else p = xu / yu;
            REM:    if (yu == 0) begin p = xu; z = 1'b1; end
                    else p = $unsigned($signed(xs) % $signed(ys));
            default: if (yu == 0) begin p = xu; z = 1'b1; end
                    else p = xu % yu;
        endcase
        p = p & mask;
        r = p[31:0];
    endfunction

    // start an op, return result/dbz and start-edge-to-done latency
    task automatic run_op(input int sel, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] res,
                          output logic z, output int lat);
        int gap;
        gap = 0;
        @(negedge clk1);
        set_in(sel, 1'b1, o, x, y, 1'b0);
        @(posedge clk1);
        @(negedge clk1);
        set_in(sel, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check("busy_after_start", {31'b0, get_busy(sel)}, 32'd1);
        lat = 0;
        do begin
            @(posedge clk1);
            lat++;
            @(negedge clk1);
            if (!get_done(sel) && !get_busy(sel)) gap++;
        end while (!get_done(sel) && lat < 100);
        check("busy_window", gap, 32'd0);
        check("busy_low_at_done", {31'b0, get_busy(sel)}, 32'd0);
        res = get_res(sel);
        z = get_dbz(sel);
        @(posedge clk1);
        @(negedge clk1);
        check("done_one_cycle", {31'b0, get_done(sel)}, 32'd0);
    endtask

    initial begin
        logic [31:0] res, res1, res2, exp_r;
        logic        z, exp_z;
        int          lat, t, t1, t2, seen;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        set_in(8, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #23;
        check("reset_busy", {31'b0, i32.busy}, 32'd0);
        check("reset_done", {31'b0, i32.done}, 32'd0);
        check("reset_result", i32.result, 32'd0);
        check("reset_dbz", {31'b0, i32.div_by_zero}, 32'd0);
        check("reset_result8", {24'b0, i8.result}, 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;

        // latency and basic multiply
        run_op(32, MUL, 32'd2, 32'd3, res, z, lat);
        check("mul_2x3", res, 32'd6);
        check("mul_latency", lat, 32'd34);
        check("mul_dbz", {31'b0, z}, 32'd0);

        run_op(32, MUL, -32'sd5, 32'd4, res, z, lat);
        check("mul_neg", res, 32'hFFFF_FFEC);
        run_op(32, MULH, -32'sd5, 32'd4, res, z, lat);
        check("mulh_neg", res, 32'hFFFF_FFFF);
        run_op(32, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, z, lat);
        check("mulhu_max", res, 32'hFFFF_FFFE);
        run_op(32, MULHSU, 32'hFFFF_FFFF, 32'd2, res, z, lat);
        check("mulhsu_neg", res, 32'hFFFF_FFFF);

        run_op(32, DIV, -32'sd7, 32'd2, res, z, lat);
        check("div_neg", res, 32'hFFFF_FFFD);
        check("div_latency", lat, 32'd34);
        run_op(32, REM, -32'sd7, 32'd2, res, z, lat);
        check("rem_neg", res, 32'hFFFF_FFFF);
        run_op(32, DIVU, 32'd200, 32'd7, res, z, lat);
        check("divu", res, 32'd28);
        run_op(32, REMU, 32'd200, 32'd7, res, z, lat);
        check("remu", res, 32'd4);

        run_op(32, DIVU, 32'd7, 32'd0, res, z, lat);
        check("divu_by0", res, 32'hFFFF_FFFF);
        check("divu_by0_flag", {31'b0, z}, 32'd1);
        check("divu_by0_latency", lat, 32'd34);
        run_op(32, REM, 32'd7, 32'd0, res, z, lat);
        check("rem_by0", res, 32'd7);
        check("rem_by0_flag", {31'b0, z}, 32'd1);

        // async reset mid-MUL clears outputs without a clock edge
        @(negedge clk1);
        set_in(32, 1'b1, MUL, 32'd6, 32'd7, 1'b0);
        @(posedge clk1);
        @(negedge clk1);
        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (5) @(posedge clk1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, i32.busy}, 32'd0);
        check("rst_mid_done", {31'b0, i32.done}, 32'd0);
        check("rst_mid_result", i32.result, 32'd0);
        check("rst_mid_dbz", {31'b0, i32.div_by_zero}, 32'd0);
        @(negedge clk1);
        rst_n = 1'b1;

        run_op(32, DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, z, lat);
        check("div_ovf", res, 32'h8000_0000);
        check("div_ovf_flag", {31'b0, z}, 32'd0);
        run_op(32, REM, 32'h8000_0000, 32'hFFFF_FFFF, res, z, lat);
        check("rem_ovf", res, 32'd0);
        run_op(32, MUL, 32'd5, 32'd5, res, z, lat);
        check("mul_5x5", res, 32'd25);

        // flush 10 cycles into a DIV
        @(negedge clk1);
        set_in(32, 1'b1, DIV, 32'd100, 32'd3, 1'b0);
        @(posedge clk1);
        @(negedge clk1);
        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (8) @(posedge clk1);
        @(negedge clk1);
        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        @(posedge clk1);
        @(negedge clk1);
        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check("flush_busy", {31'b0, i32.busy}, 32'd0);
        check("flush_done", {31'b0, i32.done}, 32'd0);
        check("flush_result_kept", i32.result, 32'd25);
        seen = 0;
        repeat (40) begin
            @(negedge clk1);
            if (i32.done) seen++;
        end
        check("flush_no_done", seen, 32'd0);

        // flush beats start in IDLE
        @(negedge clk1);
        set_in(32, 1'b1, MUL, 32'd3, 32'd3, 1'b1);
        @(negedge clk1);
        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check("flush_drops_start", {31'b0, i32.busy}, 32'd0);

        // start while busy is ignored
        @(negedge clk1);
        set_in(32, 1'b1, MUL, 32'd3, 32'd3, 1'b0);
        @(posedge clk1);
        t = 0; t1 = 0;
        do begin
            @(negedge clk1);
            if (t >= 5 && t < 8) set_in(32, 1'b1, DIVU, 32'd100, 32'd0, 1'b0);
            else                 set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            @(posedge clk1);
            t++;
            #1;
        end while (!i32.done && t < 100);
        @(negedge clk1);
        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check("busy_start_latency", t, 32'd34);
        check("busy_start_result", i32.result, 32'd9);
        check("busy_start_dbz", {31'b0, i32.div_by_zero}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk1);
            if (i32.done || i32.busy) seen++;
        end
        check("busy_start_no_second", seen, 32'd0);

        // back-to-back with start held through the done cycle
        @(negedge clk1);
        set_in(32, 1'b1, MUL, 32'd10, 32'd20, 1'b0);
        @(posedge clk1);
        @(negedge clk1);
        set_in(32, 1'b1, DIV, 32'd30, 32'd4, 1'b0);
        t = 0; t1 = 0; t2 = 0; res1 = 32'd0; res2 = 32'd0;
        while (t2 == 0 && t < 150) begin
            @(posedge clk1);
            t++;
            @(negedge clk1);
            if (i32.done && t1 == 0) begin
                t1 = t;
                res1 = i32.result;
            end else if (i32.done) begin
                t2 = t;
                res2 = i32.result;
            end
            if (t1 != 0 && t == t1 + 1) begin
                check("b2b_second_busy", {31'b0, i32.busy}, 32'd1);
                set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            end
        end
        set_in(32, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check("b2b_first_edge", t1, 32'd34);
        check("b2b_first_result", res1, 32'd200);
        check("b2b_second_edge", t2, 32'd69);
        check("b2b_second_result", res2, 32'd7);

        // WIDTH=8 directed corners
        run_op(8, DIV, 32'h80, 32'hFF, res, z, lat);
        check("w8_div_ovf", res, 32'h80);
        check("w8_latency", lat, 32'd10);
        run_op(8, MULH, 32'hFB, 32'h04, res, z, lat);
        check("w8_mulh", res, 32'hFF);

        // random regression against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            model(8, o, x, y, exp_r, exp_z);
            run_op(8, o, x, y, res, z, lat);
            check("rand8_result", res, exp_r);
            check("rand8_dbz", {31'b0, z}, {31'b0, exp_z});
            check("rand8_latency", lat, 32'd10);
        end
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 5 == 1) y = y >> $urandom_range(8, 30);
            model(32, o, x, y, exp_r, exp_z);
            run_op(32, o, x, y, res, z, lat);
            check("rand32_result", res, exp_r);
            check("rand32_dbz", {31'b0, z}, {31'b0, exp_z});
            check("rand32_latency", lat, 32'd34);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit serving the EX stage of the pipelined RISC-V core. It covers the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at any even operand width, using a start/busy/done handshake and a fixed latency. A flush input lets the pipeline abandon an in-flight operation on a taken branch.

## Interface
- WIDTH, 32, operand/result width in bits; even, >= 4
- clk1  in  1  single processor clock, rising-edge active
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  WIDTH  rs1 operand (multiplicand / dividend)
- b  in  WIDTH  rs2 operand (multiplier / divisor)
- flush  in  1  synchronous abort of the current operation
- busy  out  1  operation in progress
- done  out  1  single-cycle pulse; result valid
- result  out  WIDTH  registered result, held until the next done
- div_by_zero  out  1  qualified by done; 1 when the op is a divide/remainder with b==0

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE: if start=1, register op, a and b, then go to PREP with busy=1. Without start, stay in IDLE.
- PREP: record operand signs (a signed for MUL/MULH/MULHSU/DIV/REM; b signed for MUL/MULH/DIV/REM). Take absolute values into a 2*WIDTH working register. Load counter = WIDTH-1. Go to ITER.
- ITER, multiply: radix-2 shift-add over unsigned magnitudes, one multiplier bit per cycle.
- ITER, divide: restoring division over unsigned magnitudes, one quotient bit per cycle.
- ITER runs WIDTH cycles. When counter==0, go to FIX.
- FIX: negate the 2*WIDTH product when the operand signs differ. Quotient takes sign(a) XOR sign(b); remainder takes sign(a).
- FIX result selection: MUL returns low WIDTH bits; MULH/MULHSU/MULHU return high WIDTH bits; DIV/DIVU return the quotient; REM/REMU return the remainder.
- FIX completion: register result, pulse done=1, set busy=0, return to IDLE.
- Divide by zero: quotient = all ones; remainder = a unmodified; div_by_zero=1. Latency is unchanged.
- Signed overflow (a = -2^(WIDTH-1), b = -1, DIV/REM): quotient = -2^(WIDTH-1), remainder = 0, div_by_zero=0.
- Multiply ops always drive div_by_zero=0.
- Flush: flush=1 in PREP/ITER/FIX returns the FSM to IDLE on that edge with busy=0 and no done; result keeps its previous value. Flush has priority over start in IDLE, so start is dropped.
- start while busy=1 is ignored.
- Async reset (rst_n=0, any state, including mid-operation): state=IDLE, busy=0, done=0, result=0, div_by_zero=0, counter=0. The in-flight operation is lost.

## Timing
- Reset values of all outputs are 0.
- Clock edges, for start sampled high at rising edge N in IDLE:
  - Edge N: busy rises.
  - Edge N+1: PREP→ITER.
  - Edges N+2 … N+WIDTH+1: iterations.
  - Edge N+WIDTH+2: done rises and busy falls; result and div_by_zero become valid.
- Latency is WIDTH+2 cycles from the start edge to done, for every op and operand value. There is no early-out.
- done lasts exactly one cycle.
- Back-to-back: start asserted during the done cycle is sampled at edge N+WIDTH+3 (the FSM is in IDLE), so the next done arrives at edge N+2*WIDTH+5.
- Inputs a, b and op may change after edge N without effect.
- The operation starts in the cycle after rst_n deasserts.

## Test plan
1. WIDTH=32, timing check. After reset, MUL a=2, b=3 → result=6 with done exactly 34 edges after the start edge. Verify busy over that window and a one-cycle done.
2. Multiply signedness:
   - MUL a=-5, b=4 → 0xFFFFFFEC.
   - MULH a=-5, b=4 → 0xFFFFFFFF.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU a=-1, b=2 → 0xFFFFFFFF.
3. Divide signedness:
   - DIV -7/2 → 0xFFFFFFFD (−3).
   - REM -7/2 → 0xFFFFFFFF (−1).
   - DIVU 200/7 → 28.
   - REMU 200/7 → 4.
4. Corner cases:
   - DIVU 7/0 → 0xFFFFFFFF with div_by_zero=1.
   - REM 7/0 → 7 with div_by_zero=1.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
5. Interruptions:
   - flush 10 cycles into a DIV → no done, busy=0 next cycle, result keeps its prior value.
   - rst_n pulsed low mid-MUL → all outputs 0 asynchronously.
   - start during busy → ignored.
6. Back-to-back: MUL 10×20 then DIV 30/4 with start held through the done cycle → results 200, then 7, second done at edge N+69. Run a random regression against a reference model at WIDTH=8 and WIDTH=32.
